dct_pixel_sequencer: RTL
========================

// Module: dct_pixel_sequencer
// PURPOSE
//  Feeds the 4x4 float DCT accumulate stage from an 8-bit pixel stream, one pixel at a time.
//  Per pixel: converts the pixel to IEEE-754 fp32 and drives the pixel coordinates nx/ny.
//  Schedules the accumulator RAM read and write-back so each of the 16 sums per block is
//  read only after the previous update is written. Substitutes zero sums for the first pixel of a block.
// PARAMETERS
//  COS_LAT     5   cosine-product multiplier latency (CLK)
//  MUL_LAT     5   data x cosine multiplier latency
//  ADD_LAT     7   accumulate adder latency
//  RD_LAT      1   accumulator RAM read latency
//  NUM_BLOCKS  64  4x4 blocks per frame
//  BLK_AW      6   block address width, 2**BLK_AW >= NUM_BLOCKS
// PORTS
//  CLK          in   1    clock, rising edge
//  Reset        in   1    asynchronous, active-high reset
//  CE           in   1    clock enable; shared with the downstream FP pipeline
//  pix_i        in   8    unsigned pixel, raster order inside block (nx fastest)
//  pix_valid_i  in   1    pixel valid
//  pix_ready_o  out  1    pixel accepted at the edge where valid&ready&CE
//  data_o       out  32   fp32 pixel to the DCT stage
//  nx_o, ny_o   out  2,2  pixel column/row to the DCT stage
//  ram_rd_en_o  out  1    accumulator RAM read strobe
//  ram_rd_addr_o out BLK_AW  read address (block index)
//  ram_q1_i, ram_q2_i  in 256  RAM read data (coeffs 0-7, 8-15)
//  d1_o, d2_o   out  256  accumulator inputs to the DCT stage (RAM data or zero)
//  ram_wr_en_o  out  1    write-back strobe for the DCT stage sum outputs
//  ram_wr_addr_o out BLK_AW  write address
//  blk_done_o   out  1    1-CLK pulse with the write of a block's 16th pixel
//  frame_done_o out  1    1-CLK pulse with blk_done_o of block NUM_BLOCKS-1
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, nx=ny=blk=0, token pipe empty. Reset mid-frame abandons the
//   partial block; the next pixel is treated as pixel (0,0) of block 0. RAM contents are not cleared.
//  CE=0: every register holds, including the FSM, counters, token pipe and strobes. ready is forced 0.
//  Issue period P = ADD_LAT+RD_LAT+1 (=9). FSM: IDLE (ready=CE) -> on accept -> GAP.
//   GAP counts P-1 CE cycles, ready=0 -> IDLE. Max throughput: 1 pixel / P CLK.
//  Timing with accept edge = cycle 0, in CE cycles, defaults:
//   c1: nx_o/ny_o = coords of this pixel, held until the next accept's c1.
//   c1+COS_LAT (6): data_o = fp32(pix), held likewise.
//   c1+COS_LAT+MUL_LAT-RD_LAT (10): ram_rd_en_o=1, rd_addr=blk.
//   c11: d1_o/d2_o = ram_q (combinational pass). Forced to 256'h0 if the pixel is (0,0).
//   c11+ADD_LAT (18): ram_wr_en_o=1, wr_addr=blk; blk_done/frame_done if the pixel is (3,3).
//   Next read (c9+10=19) > write (18): no read-after-write hazard. P is not reducible.
//  Token pipe: per accept, a valid bit plus {blk, first, last} shifted each CE, length 18. Strobes are decoded from taps.
//  Counters: after an accept, nx++. When nx wraps 3->0, ny++. When ny wraps, blk++.
//   blk wraps NUM_BLOCKS-1 -> 0.
//  Conversion: pix 0 -> 32'h0, else exponent = 127+msb_index, mantissa = bits below the msb,
//   left-aligned. Exact, no rounding.
//  pix_valid_i is ignored while ready=0. pix_i is sampled only on accept.
// TESTING
//  1) Reset, then pix 0,1,128,255 -> data_o 32'h0, 3F800000, 43000000, 437F0000, each 6 cycles after accept.
//  2) Continuous valid, 16 pixels -> accepts spaced exactly 9 cycles apart. nx/ny run (0,0),(1,0)..(3,3).
//   Eight wr pulses... (one per pixel) at accept+18, wr_addr 0; blk_done with the 16th.
//  3) First pixel of block 5 with ram_q = all 32'h3F800000 -> d1_o/d2_o = 0 at c11. Second pixel -> d = ram_q.
//  4) 64x16 pixels -> frame_done once with the last block's write. The next pixel gets blk=0, (0,0).
//  5) CE low 3 cycles at c4 -> all strobes shift by exactly 3 cycles. No extra or lost pulse.
//  6) Reset asserted at c12 of pixel (2,1) -> strobes cleared immediately. No wr pulse.
//   The next accept is (0,0), blk 0.
```

Note: test 2 in the TESTING block contains a typo. It should read "16 wr pulses (one per pixel) at accept+18, wr_addr 0; blk_done with the 16th." It should not say "Eight wr pulses...".

Source files
------------

// File: rtl/dct_pixel_sequencer.sv
// dct_pixel_sequencer: turns an 8-bit raster pixel stream into fp32 samples for
// the 4x4 float DCT accumulate stage and schedules the accumulator RAM
// read / write-back so every block sum is read only after its previous update
// has been written.
//
// Pipeline timing in CE cycles, relative to the accept edge (edge 0):
//   tok_vld[k] is loaded at edge k. A registered output loaded at edge N reads
//   tap N-1. A combinational output valid after edge N reads tap N.
module dct_pixel_sequencer #(
  parameter int COS_LAT    = 5,
  parameter int MUL_LAT    = 5,
  parameter int ADD_LAT    = 7,
  parameter int RD_LAT     = 1,
  parameter int NUM_BLOCKS = 64,
  parameter int BLK_AW     = 6
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              CE,
  input  logic [7:0]        pix_i,
  input  logic              pix_valid_i,
  output logic              pix_ready_o,
  output logic [31:0]       data_o,
  output logic [1:0]        nx_o,
  output logic [1:0]        ny_o,
  output logic              ram_rd_en_o,
  output logic [BLK_AW-1:0] ram_rd_addr_o,
  input  logic [255:0]      ram_q1_i,
  input  logic [255:0]      ram_q2_i,
  output logic [255:0]      d1_o,
  output logic [255:0]      d2_o,
  output logic              ram_wr_en_o,
  output logic [BLK_AW-1:0] ram_wr_addr_o,
  output logic              blk_done_o,
  output logic              frame_done_o
);

  // Issue period: the next read of a sum must land after the write of its
  // previous update (read at c(P)+rd offset > write at c(rd)+RD_LAT+ADD_LAT).
  localparam int PERIOD   = ADD_LAT + RD_LAT + 1;
  localparam int CW       = $clog2(PERIOD);
  // Last token tap; the write strobe is loaded from it.
  localparam int STAGES   = COS_LAT + MUL_LAT + ADD_LAT;
  localparam int DATA_TAP = COS_LAT;
  localparam int RD_TAP   = COS_LAT + MUL_LAT - RD_LAT;
  localparam int D_TAP    = RD_TAP + RD_LAT + 1;
  localparam logic [BLK_AW-1:0] LAST_BLK = BLK_AW'(NUM_BLOCKS - 1);

  typedef enum logic {IDLE, GAP} state_t;

  state_t       state, state_nxt;
  logic [CW-1:0] gap_cnt, gap_cnt_nxt;
  logic         accept;

  // Coordinate / block counters of the next pixel to be accepted.
  logic [1:0]        nx, ny;
  logic [BLK_AW-1:0] blk;

  // Captured at accept, consumed by the delayed output registers.
  logic [7:0] pix_q;
  logic [1:0] cur_nx, cur_ny;

  // Token pipe: valid bit plus {blk, first, last} per accepted pixel.
  logic [STAGES:0]             tok_vld;
  logic [STAGES:0][BLK_AW-1:0] tok_blk;
  logic [D_TAP:0]              tok_first;
  logic [STAGES:0]             tok_last;

  logic zero_sum;

  // Exact u8 -> fp32: every 8-bit integer fits in the 23-bit mantissa.
  function automatic logic [31:0] to_fp32(input logic [7:0] p);
    logic [2:0]  msb;
    logic [22:0] mant;
    logic [7:0]  expo;
    msb = 3'd0;
    for (int i = 0; i < 8; i++)
      if (p[i]) msb = 3'(i);
    // Leading one shifts out of the 23-bit field, leaving the fraction bits.
    mant = 23'(p) << (5'd23 - {2'b00, msb});
    expo = 8'd127 + {5'b00000, msb};
    return (p == 8'd0) ? 32'h0 : {1'b0, expo, mant};
  endfunction

  assign pix_ready_o = (state == IDLE) && CE && !Reset;
  assign accept      = pix_valid_i && pix_ready_o;

  // FSM state register; frozen while CE is low.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else if (CE) begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  // Next state: one accept, then PERIOD-1 CE cycles of not-ready.
  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt   = GAP;
          gap_cnt_nxt = '0;
        end
      end
      GAP: begin
        if (gap_cnt == CW'(PERIOD - 2)) state_nxt = IDLE;
        else                            gap_cnt_nxt = gap_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Raster counters inside the frame plus per-accept capture of pixel/coords.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      nx     <= '0;
      ny     <= '0;
      blk    <= '0;
      pix_q  <= '0;
      cur_nx <= '0;
      cur_ny <= '0;
    end else if (accept) begin
      pix_q  <= pix_i;
      cur_nx <= nx;
      cur_ny <= ny;
      nx     <= nx + 2'd1;
      if (nx == 2'd3) begin
        ny <= ny + 2'd1;
        if (ny == 2'd3) blk <= (blk == LAST_BLK) ? '0 : blk + 1'b1;
      end
    end
  end

  // Token shift register; accept already implies CE.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      tok_vld   <= '0;
      tok_blk   <= '0;
      tok_first <= '0;
      tok_last  <= '0;
    end else if (CE) begin
      tok_vld   <= {tok_vld[STAGES-1:0], accept};
      tok_blk   <= {tok_blk[STAGES-1:0], blk};
      tok_first <= {tok_first[D_TAP-1:0], (nx == 2'd0) && (ny == 2'd0)};
      tok_last  <= {tok_last[STAGES-1:0], (nx == 2'd3) && (ny == 2'd3)};
    end
  end

  // Coordinates and fp32 sample, each held until the next pixel reaches it.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      nx_o   <= '0;
      ny_o   <= '0;
      data_o <= '0;
    end else if (CE) begin
      if (tok_vld[0]) begin
        nx_o <= cur_nx;
        ny_o <= cur_ny;
      end
      if (tok_vld[DATA_TAP]) data_o <= to_fp32(pix_q);
    end
  end

  // RAM read / write-back strobes and block / frame completion pulses.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ram_rd_en_o   <= 1'b0;
      ram_rd_addr_o <= '0;
      ram_wr_en_o   <= 1'b0;
      ram_wr_addr_o <= '0;
      blk_done_o    <= 1'b0;
      frame_done_o  <= 1'b0;
    end else if (CE) begin
      ram_rd_en_o  <= tok_vld[RD_TAP];
      if (tok_vld[RD_TAP]) ram_rd_addr_o <= tok_blk[RD_TAP];
      ram_wr_en_o  <= tok_vld[STAGES];
      if (tok_vld[STAGES]) ram_wr_addr_o <= tok_blk[STAGES];
      blk_done_o   <= tok_vld[STAGES] && tok_last[STAGES];
      frame_done_o <= tok_vld[STAGES] && tok_last[STAGES] &&
                      (tok_blk[STAGES] == LAST_BLK);
    end
  end

  // First pixel of a block starts from zero sums instead of stale RAM data.
  assign zero_sum = Reset || (tok_vld[D_TAP] && tok_first[D_TAP]);
  assign d1_o     = zero_sum ? 256'h0 : ram_q1_i;
  assign d2_o     = zero_sum ? 256'h0 : ram_q2_i;

endmodule
